// File: rtl/fm_input_capture.sv
// Per-channel frequency-meter input stage: synchronises fin_i, detects rising
// edges and performs a reciprocal measurement (reference clocks spanning a
// programmed number of input periods). The result is handed over with a valid/ack
// handshake.
module fm_input_capture #(
  parameter int unsigned CNT_WIDTH    = 30,
  parameter int unsigned PERIOD_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    fin_i,
  input  logic                    enable_i,
  input  logic                    start_i,
  input  logic [PERIOD_WIDTH-1:0] periods_i,
  output logic                    busy_o,
  output logic                    result_valid_o,
  input  logic                    result_ack_i,
  output logic [CNT_WIDTH-1:0]    ref_count_o,
  output logic [PERIOD_WIDTH-1:0] period_count_o,
  output logic                    overflow_o
);

  typedef enum logic [1:0] {StIdle, StArm, StMeasure, StDone} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              fin_sync_q, fin_sync_d;
  logic [CNT_WIDTH-1:0]    ref_cnt_q, ref_cnt_d;
  logic [PERIOD_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [PERIOD_WIDTH-1:0] target_q, target_d;
  logic [CNT_WIDTH-1:0]    ref_count_q, ref_count_d;
  logic [PERIOD_WIDTH-1:0] period_count_q, period_count_d;
  logic                    overflow_q, overflow_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;

  logic                    edge_pulse;
  logic [PERIOD_WIDTH-1:0] edge_cnt_inc;
  logic                    ref_cnt_sat;

  // Two-flop synchroniser plus a third stage used only for edge detection.
  assign fin_sync_d   = {fin_sync_q[1:0], fin_i};
  assign edge_pulse   = fin_sync_q[1] & ~fin_sync_q[2];
  assign edge_cnt_inc = edge_cnt_q + PERIOD_WIDTH'(edge_pulse);
  assign ref_cnt_sat  = (ref_cnt_q == {CNT_WIDTH{1'b1}});

  // Next-state and captured-result logic of the measurement FSM.
  always_comb begin
    state_d        = state_q;
    ref_cnt_d      = ref_cnt_q;
    edge_cnt_d     = edge_cnt_q;
    target_d       = target_q;
    ref_count_d    = ref_count_q;
    period_count_d = period_count_q;
    overflow_d     = overflow_q;
    busy_d         = busy_q;
    valid_d        = valid_q;

    if (!enable_i) begin
      // Abort: captured results are deliberately left untouched.
      state_d = StIdle;
      busy_d  = 1'b0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i && (periods_i != '0)) begin
            target_d   = periods_i;
            overflow_d = 1'b0;
            busy_d     = 1'b1;
            state_d    = StArm;
          end
        end
        StArm: begin
          if (edge_pulse) begin
            ref_cnt_d  = '0;
            edge_cnt_d = '0;
            state_d    = StMeasure;
          end
        end
        StMeasure: begin
          ref_cnt_d  = ref_cnt_sat ? ref_cnt_q : ref_cnt_q + 1'b1;
          edge_cnt_d = edge_cnt_inc;
          // Saturation wins over a coinciding final edge: ref_cnt + 1 would not fit.
          if (ref_cnt_sat) begin
            ref_count_d    = {CNT_WIDTH{1'b1}};
            period_count_d = edge_cnt_inc;
            overflow_d     = 1'b1;
            busy_d         = 1'b0;
            valid_d        = 1'b1;
            state_d        = StDone;
          end else if (edge_pulse && (edge_cnt_inc == target_q)) begin
            ref_count_d    = ref_cnt_q + 1'b1;
            period_count_d = target_q;
            busy_d         = 1'b0;
            valid_d        = 1'b1;
            state_d        = StDone;
          end
        end
        StDone: begin
          // Ack takes priority; a simultaneous start is simply not looked at here.
          if (result_ack_i) begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and result registers, asynchronously cleared.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= StIdle;
      fin_sync_q     <= '0;
      ref_cnt_q      <= '0;
      edge_cnt_q     <= '0;
      target_q       <= '0;
      ref_count_q    <= '0;
      period_count_q <= '0;
      overflow_q     <= 1'b0;
      busy_q         <= 1'b0;
      valid_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      fin_sync_q     <= fin_sync_d;
      ref_cnt_q      <= ref_cnt_d;
      edge_cnt_q     <= edge_cnt_d;
      target_q       <= target_d;
      ref_count_q    <= ref_count_d;
      period_count_q <= period_count_d;
      overflow_q     <= overflow_d;
      busy_q         <= busy_d;
      valid_q        <= valid_d;
    end
  end

  assign busy_o         = busy_q;
  assign result_valid_o = valid_q;
  assign ref_count_o    = ref_count_q;
  assign period_count_o = period_count_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_fm_input_capture.sv
// Bench for fm_input_capture with an 8-bit reference counter so saturation is
// reachable quickly. Expected results come from hand tables and an arithmetic
// model of the reciprocal measurement.
module tb_fm_input_capture;

  localparam int CW   = 8;
  localparam int PW   = 16;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          fin_i;
  logic          enable_i;
  logic          start_i;
  logic [PW-1:0] periods_i;
  logic          busy_o;
  logic          result_valid_o;
  logic          result_ack_i;
  logic [CW-1:0] ref_count_o;
  logic [PW-1:0] period_count_o;
  logic          overflow_o;

  fm_input_capture #(
    .CNT_WIDTH    (CW),
    .PERIOD_WIDTH (PW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .fin_i          (fin_i),
    .enable_i       (enable_i),
    .start_i        (start_i),
    .periods_i      (periods_i),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .result_ack_i   (result_ack_i),
    .ref_count_o    (ref_count_o),
    .period_count_o (period_count_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Square-wave generator state, advanced once per clock by tick().
  bit fin_run = 1'b0;
  int fin_hi  = 1;
  int fin_lo  = 1;
  int fin_ph  = 0;

  typedef struct {
    int hi;
    int lo;
    int n;
    int er;
    int ep;
    int eo;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (fin_run) begin
      fin_ph++;
      if (fin_ph >= fin_hi + fin_lo) fin_ph = 0;
      fin_i = (fin_ph < fin_hi);
    end
  endtask

  // Reciprocal measurement from first principles: the N-th edge after the
  // first arrives N*P clocks later; the counter saturates after MAXC+1 clocks,
  // by which time floor((MAXC+1)/P) edges have been seen.
  function automatic void model(input int p, input int n, output int er, output int ep,
                                output int eo);
    if (n * p <= MAXC) begin
      er = n * p;
      ep = n;
      eo = 0;
    end else begin
      er = MAXC;
      ep = (MAXC + 1) / p;
      eo = 1;
    end
  endfunction

  // Restart the wave cleanly so every edge seen by the DUT is exactly P apart.
  task automatic restart_wave(input int hi, input int lo);
    fin_run = 1'b0;
    fin_i   = 1'b0;
    repeat (4) tick();
    fin_hi  = hi;
    fin_lo  = lo;
    fin_ph  = hi + lo - 1;
    fin_run = 1'b1;
  endtask

  task automatic wait_valid(input int bound, input string tag);
    int k;
    k = 0;
    while (!result_valid_o && k < bound) begin
      tick();
      k++;
    end
    if (!result_valid_o) check({tag, "_timeout"}, result_valid_o, 1);
  endtask

  task automatic run_meas(input int hi, input int lo, input int n, input bit do_ack,
                          input int er, input int ep, input int eo, input string tag);
    bit seen;
    restart_wave(hi, lo);
    repeat ($urandom_range(0, hi + lo - 1)) tick();
    start_i   = 1'b1;
    periods_i = PW'(n);
    tick();
    start_i = 1'b0;
    if (n == 0) begin
      check({tag, "_busy_zero"}, busy_o, 0);
      seen = 1'b0;
      repeat (30) begin
        tick();
        if (result_valid_o || busy_o) seen = 1'b1;
      end
      check({tag, "_no_result"}, seen, 0);
      return;
    end
    check({tag, "_busy"}, busy_o, 1);
    wait_valid(1000, tag);
    check({tag, "_ref"}, ref_count_o, er);
    check({tag, "_per"}, period_count_o, ep);
    check({tag, "_ovf"}, overflow_o, eo);
    check({tag, "_busy_done"}, busy_o, 0);
    if (do_ack) begin
      result_ack_i = 1'b1;
      tick();
      result_ack_i = 1'b0;
      check({tag, "_valid_fall"}, result_valid_o, 0);
      check({tag, "_ref_held"}, ref_count_o, er);
    end
  endtask

  initial begin
    int  p, hi, n, er, ep, eo;
    bit  seen;

    vecs[0] = '{hi: 5,  lo: 5,  n: 4,   er: 40,  ep: 4,   eo: 0};
    vecs[1] = '{hi: 3,  lo: 4,  n: 1,   er: 7,   ep: 1,   eo: 0};
    vecs[2] = '{hi: 2,  lo: 2,  n: 10,  er: 40,  ep: 10,  eo: 0};
    vecs[3] = '{hi: 1,  lo: 1,  n: 100, er: 200, ep: 100, eo: 0};
    vecs[4] = '{hi: 20, lo: 20, n: 7,   er: 255, ep: 6,   eo: 1};
    vecs[5] = '{hi: 3,  lo: 3,  n: 0,   er: 0,   ep: 0,   eo: 0};

    rst_i        = 1'b0;
    fin_i        = 1'b0;
    enable_i     = 1'b1;
    start_i      = 1'b0;
    periods_i    = '0;
    result_ack_i = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy_o, 0);
    check("rst_valid", result_valid_o, 0);
    check("rst_ref", ref_count_o, 0);
    check("rst_per", period_count_o, 0);
    check("rst_ovf", overflow_o, 0);
    @(negedge clk);
    rst_i = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_meas(vecs[i].hi, vecs[i].lo, vecs[i].n, 1'b1, vecs[i].er, vecs[i].ep, vecs[i].eo,
               $sformatf("vec%0d", i));
    end

    // Single rising edge, then held low: counter must saturate.
    fin_run = 1'b0;
    fin_i   = 1'b0;
    repeat (4) tick();
    start_i   = 1'b1;
    periods_i = 16'd3;
    tick();
    start_i = 1'b0;
    check("ovf_busy", busy_o, 1);
    fin_i = 1'b1;
    repeat (3) tick();
    fin_i = 1'b0;
    wait_valid(400, "ovf");
    check("ovf_ref", ref_count_o, MAXC);
    check("ovf_per", period_count_o, 0);
    check("ovf_flag", overflow_o, 1);
    result_ack_i = 1'b1;
    tick();
    result_ack_i = 1'b0;
    check("ovf_ack", result_valid_o, 0);

    // Backpressure: result must hold while fin toggles and starts are ignored.
    run_meas(5, 5, 4, 1'b0, 40, 4, 0, "bp");
    for (int i = 0; i < 20; i++) begin
      start_i   = (i % 3 == 0);
      periods_i = 16'd2;
      tick();
      start_i = 1'b0;
      check("bp_valid", result_valid_o, 1);
      check("bp_busy", busy_o, 0);
      check("bp_ref", ref_count_o, 40);
      check("bp_per", period_count_o, 4);
    end
    start_i      = 1'b1;
    result_ack_i = 1'b1;
    tick();
    start_i      = 1'b0;
    result_ack_i = 1'b0;
    check("coll_valid", result_valid_o, 0);
    check("coll_busy", busy_o, 0);
    tick();
    check("coll_no_start", busy_o, 0);

    // Abort mid-measurement via enable.
    restart_wave(5, 5);
    start_i   = 1'b1;
    periods_i = 16'd100;
    tick();
    start_i = 1'b0;
    check("abort_busy", busy_o, 1);
    repeat (40) tick();
    enable_i = 1'b0;
    tick();
    check("abort_busy_fall", busy_o, 0);
    check("abort_valid", result_valid_o, 0);
    tick();
    enable_i = 1'b1;
    seen = 1'b0;
    repeat (300) begin
      tick();
      if (result_valid_o || busy_o) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);
    check("abort_ref_kept", ref_count_o, 40);
    check("abort_per_kept", period_count_o, 4);

    // Randomised measurements against the arithmetic model.
    for (int it = 0; it < 30; it++) begin
      p  = int'($urandom_range(2, 40));
      hi = int'($urandom_range(1, p - 1));
      n  = int'($urandom_range(1, 15));
      model(p, n, er, ep, eo);
      run_meas(hi, p - hi, n, 1'b1, er, ep, eo, $sformatf("rnd%0d_p%0d_n%0d", it, p, n));
    end

    // Asynchronous reset in the middle of a measurement.
    restart_wave(5, 5);
    start_i   = 1'b1;
    periods_i = 16'd20;
    tick();
    start_i = 1'b0;
    repeat (30) tick();
    check("mid_busy", busy_o, 1);
    @(posedge clk);
    #3;
    rst_i = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_valid", result_valid_o, 0);
    check("arst_ref", ref_count_o, 0);
    check("arst_per", period_count_o, 0);
    check("arst_ovf", overflow_o, 0);
    @(negedge clk);
    rst_i = 1'b1;
    run_meas(5, 5, 4, 1'b1, 40, 4, 0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fm_input_capture.md
Name: fm_input_capture

Overview:
- Per-channel input stage of the frequency meter. Sits between one external Fin pin and the measurement/Wishbone register logic inside top.
- Synchronises the asynchronous input and detects its rising edges.
- Performs a reciprocal measurement: counts clk_i cycles spanning a programmed number of input periods.
- Presents the result through a valid/ack handshake. One instance per Fin bit (F_INPUTS_COUNT instances).

Parameters:
- CNT_WIDTH, 30, width of the reference-clock counter and ref_count_o.
- PERIOD_WIDTH, 16, width of the period target and period counter.

Ports:
- clk_i  input  1  system clock; all logic on its rising edge.
- rst_i  input  1  reset; asynchronous, active-low.
- fin_i  input  1  raw asynchronous frequency input.
- enable_i  input  1  channel enable; low aborts to IDLE.
- start_i  input  1  one-cycle request to begin a measurement.
- periods_i  input  PERIOD_WIDTH  number of input periods to measure; sampled on an accepted start.
- busy_o  output  1  high in ARM and MEASURE.
- result_valid_o  output  1  result available (DONE state).
- result_ack_i  input  1  consumer acknowledge.
- ref_count_o  output  CNT_WIDTH  clk_i cycles between the first and last counted edge.
- period_count_o  output  PERIOD_WIDTH  input periods actually counted.
- overflow_o  output  1  reference counter saturated during this measurement.

Behaviour:
- Reset (rst_i=0, async):
  - All outputs 0. Synchroniser flops 0. State IDLE. Internal counters and latched target 0.
- Input conditioning:
  - 2-FF synchroniser, then a third flop for edge detect; edge = s2 & ~s3.
  - fin_i rising edge to internal edge pulse: 3 clk_i cycles.
  - Edge pulse is exactly 1 cycle wide.
  - Pulses shorter than one clk_i period may be missed; this is not flagged.
- States: IDLE, ARM, MEASURE, DONE.
- IDLE:
  - start_i=1 & enable_i=1 & periods_i!=0: latch target=periods_i, clear overflow_o, go ARM.
  - periods_i==0: start ignored; stay IDLE.
- ARM:
  - Waits indefinitely for the first edge.
  - On edge: ref_cnt<=0, edge_cnt<=0, go MEASURE.
- MEASURE, every cycle:
  - ref_cnt<=ref_cnt+1.
  - On edge, edge_cnt<=edge_cnt+1.
  - If edge & edge_cnt+1==target: ref_count_o<=ref_cnt+1, period_count_o<=target, go DONE.
  - Result for an input of period P clocks over N periods: ref_count_o = N*P exactly.
- Overflow:
  - Applies if ref_cnt==all-ones in MEASURE before the target is reached.
  - ref_count_o<=all-ones, period_count_o<=edge_cnt (incl. an edge in that cycle), overflow_o<=1, go DONE.
- DONE:
  - result_valid_o=1; outputs held stable until the cycle after result_ack_i=1.
  - On ack, go IDLE; result_valid_o falls next cycle.
  - ref_count_o, period_count_o and overflow_o keep their values until the next accepted start. overflow_o clears on that start.
- busy_o:
  - Registered; 1 in ARM/MEASURE, 0 otherwise.
  - Rises the cycle after an accepted start.
- start_i outside IDLE: ignored (no restart, no error).
- result_ack_i outside DONE: ignored.
- Simultaneous start_i and result_ack_i in DONE: ack processed, start ignored.
- enable_i=0 in any state:
  - Next state IDLE; result_valid_o and busy_o go 0 next cycle.
  - Captured outputs are not modified; the synchroniser keeps running.
- Arithmetic:
  - Counters are unsigned.
  - ref_cnt saturates, never wraps.
  - edge_cnt cannot exceed target.

Test Plan:
- Reset: assert rst_i=0 mid-MEASURE, asynchronously -> all outputs 0 immediately; state IDLE; after release a fresh start works normally.
- Nominal: fin_i square wave 5 clk high / 5 clk low, periods_i=4, start -> busy_o=1 one cycle after start; result_valid_o=1 with ref_count_o=40, period_count_o=4, overflow_o=0; ack -> result_valid_o=0 next cycle.
- Single period and zero:
  - Period 7 clocks, periods_i=1 -> ref_count_o=7.
  - periods_i=0 with start -> busy_o stays 0, no result.
- Overflow (CNT_WIDTH=8): fin_i one rising edge then held low, periods_i=3 -> result_valid_o=1 with ref_count_o=255, period_count_o=0, overflow_o=1.
- Backpressure and collisions:
  - Hold result_ack_i=0 for 20 cycles in DONE while fin_i toggles and start_i pulses -> outputs unchanged, no new measurement.
  - start_i and result_ack_i together -> returns to IDLE, busy_o=0.
- Abort: deassert enable_i during MEASURE with periods_i=100 -> busy_o=0 next cycle, result_valid_o never asserts, previous ref_count_o retained.
